serial_adder: RTL and testbench

- Parametrised bit-serial adder: takes two WIDTH-bit operands, adds them LSB-first, one bit per clock.
- Uses a single full-adder cell plus a carry flip-flop, so hardware cost stays flat as WIDTH grows.
- Successor to the combinational half-adder cell; reused as the arithmetic core of multi-cycle datapath exercises.
- start/busy/done handshake towards a controlling FSM.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_fa.sv | 20 ++
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings
// and the default operand width.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Gate-level full adder cell: two XOR, two AND, one OR.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g;
    logic t;

    xor u_x0 (p, x, y);
    xor u_x1 (s, p, cin);
    and u_a0 (g, x, y);
    and u_a1 (t, p, cin);
    or  u_o0 (cout, g, t);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one full-adder cell plus carry flop.
// SERIAL_ADDER_SUB_EN adds a sub input (a-b) and an ovf output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_SUB_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t state;
    state_t nxt;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rsum;
    logic [WIDTH-1:0] rsum_n;
    logic [WIDTH-1:0] sbit;
    logic [CNT_W-1:0] cnt;
    logic             cff;
    logic             fa_s;
    logic             fa_c;
    logic             sub_i;
    logic             load;
    logic             shifting;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    assign shifting = (state == S_SHIFT);
    assign load     = start & ((state == S_IDLE) | (state == S_DONE));
    assign last     = shifting & (cnt == CNT_W'(WIDTH - 1));

    full_adder_cell u_fa (
        .x    (ra[0]),
        .y    (rb[0]),
        .cin  (cff),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB while the register shifts right.
    always_comb begin
        sbit            = '0;
        sbit[WIDTH-1]   = fa_s;
        rsum_n          = (rsum >> 1) | sbit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = S_SHIFT;
            S_SHIFT: if (last) nxt = S_DONE;
            S_DONE:  nxt = start ? S_SHIFT : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (1'b1)
            (state == S_SHIFT): busy = ~rst;
            (state == S_DONE):  done = ~rst;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            rsum  <= '0;
            cff   <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (load) begin
            ra   <= a;
            rb   <= sub_i ? ~b : b;
            cff  <= sub_i;
            cnt  <= '0;
        end else if (shifting) begin
            ra   <= ra >> 1;
            rb   <= rb >> 1;
            rsum <= rsum_n;
            cff  <= fa_c;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                sum   <= rsum_n;
                carry <= fa_c;
            end
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    // On the MSB step cff is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= cff ^ fa_c;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed plan plus random ops
// against an arithmetic reference model (WIDTH=8 and WIDTH=1).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
    logic       busy;
    logic       done;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] sum1;
    logic       carry1;
    logic       busy1;
    logic       done1;

`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
    logic       sub1;
    logic       ovf;
    logic       ovf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub1),
`endif
        .a     (a1),
        .b     (b1),
        .sum   (sum1),
        .carry (carry1),
        .busy  (busy1),
        .done  (done1)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .ovf   (ovf1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned a+b or a-b (a + 2^W - b) with W+1 bit result.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic s, input string tag);
        logic [8:0] exp;
        logic       eovf;
        int         nb;
        int         early;
        exp  = s ? (9'(x) + 9'd256 - 9'(y)) : (9'(x) + 9'(y));
        eovf = s ? ((x[7] != y[7]) && (exp[7] != x[7]))
                 : ((x[7] == y[7]) && (exp[7] != x[7]));
        a = x;
        b = y;
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`endif
        start = 1'b1;
        @(posedge clk);
        nb    = 0;
        early = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            nb    += int'(busy);
            early += int'(done);
        end
        @(negedge clk);
        chk({tag, ".busy_cycles"}, nb, 8);
        chk({tag, ".early_done"}, early, 0);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_off"}, busy, 0);
        chk({tag, ".sum"}, sum, exp[7:0]);
        chk({tag, ".carry"}, carry, exp[8]);
`ifdef SERIAL_ADDER_SUB_EN
        chk({tag, ".ovf"}, ovf, eovf);
`else
        if (eovf && s) $display("unreachable");
`endif
    endtask

    task automatic run1(input logic x, input logic y, input logic s,
                        input string tag);
        logic [1:0] exp;
        exp = s ? (2'(x) + 2'd2 - 2'(y)) : (2'(x) + 2'(y));
        a1 = x;
        b1 = y;
`ifdef SERIAL_ADDER_SUB_EN
        sub1 = s;
`endif
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        chk({tag, ".busy"}, busy1, 1);
        chk({tag, ".early_done"}, done1, 0);
        @(negedge clk);
        chk({tag, ".done"}, done1, 1);
        chk({tag, ".sum"}, sum1, exp[0]);
        chk({tag, ".carry"}, carry1, exp[1]);
`ifdef SERIAL_ADDER_SUB_EN
        chk({tag, ".ovf"}, ovf1, (x == (s ? ~y : y)) && (exp[0] != x));
`endif
    endtask

    initial begin
        int nb;
        int nd;
        logic s;
        logic [7:0] x;
        logic [7:0] y;

        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        a      = '0;
        b      = '0;
        a1     = '0;
        b1     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub    = 1'b0;
        sub1   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.sum", sum, 0);
        chk("rst.carry", carry, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.sum1", {carry1, sum1}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Plan 1 and 2 (second op started in the done cycle)
        run8(8'h5A, 8'h3C, 1'b0, "t1");
        @(negedge clk);
        run8(8'hFF, 8'h01, 1'b0, "t2a");
        run8(8'h80, 8'h80, 1'b0, "t2b");
        @(negedge clk);

        // Plan 3: start while busy is ignored
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        @(posedge clk);
        nb = 0;
        nd = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 3) begin
                a = 8'hFF;
                start = 1'b1;
            end
            nb += int'(busy);
            nd += int'(done);
        end
        @(negedge clk);
        chk("t3.busy_cycles", nb, 8);
        chk("t3.early_done", nd, 0);
        chk("t3.done", done, 1);
        chk("t3.sum", sum, 8'h02);
        chk("t3.carry", carry, 0);
        @(negedge clk);
        chk("t3.idle_after", busy, 0);

        // Plan 4: reset mid-operation
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t4.sum", sum, 0);
        chk("t4.carry", carry, 0);
        chk("t4.busy", busy, 0);
        chk("t4.done", done, 0);
        rst = 1'b0;
        nd = 0;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            nd += int'(done);
            nb += int'(busy);
        end
        chk("t4.no_done", nd, 0);
        chk("t4.no_busy", nb, 0);

        // Plan 5: WIDTH=1 as a registered half adder
        for (int k = 0; k < 4; k++) begin
            run1(k[1], k[0], 1'b0, $sformatf("t5.%0d", k));
            @(negedge clk);
        end

`ifdef SERIAL_ADDER_SUB_EN
        // Plan 6: subtraction
        run8(8'h10, 8'h20, 1'b1, "t6a");
        @(negedge clk);
        run8(8'h80, 8'h01, 1'b1, "t6b");
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            run1(k[1], k[0], 1'b1, $sformatf("t6w1.%0d", k));
            @(negedge clk);
        end
`endif

        // Random operations, mixing idle gaps and back-to-back starts
        for (int n = 0; n < 40; n++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`endif
            if (n % 8 == 0) x = 8'hFF;
            if (n % 8 == 1) y = 8'h00;
            run8(x, y, s, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
